// File: rtl/exp4_unidade_controle.sv
// Control unit for the memory game: a Moore FSM that sequences the datapath one move at a time.
// Optional move timeout is built only when the TIMEOUT_EN macro is defined.
module exp4_unidade_controle #(
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARACAO    = 4'h1,
      ESPERA_JOGADA = 4'h2,
      REGISTRA      = 4'h4,
      COMPARACAO    = 4'h5,
      PROXIMO       = 4'h6,
      FIM_ACERTOU   = 4'hA,
      FIM_TIMEOUT   = 4'hD,
      FIM_ERROU     = 4'hE
   } state_t;

   state_t state;
   state_t next_state;
   logic   expirou_c;
   logic   n_zera;
   logic   n_conta;
   logic   n_registra;
   logic   n_pronto;
   logic   n_acertou;
   logic   n_errou;

`ifdef TIMEOUT_EN
   localparam logic [15:0] ULTIMO = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] contagem;
   logic        n_timeout;

   // Idle-cycle counter: runs only while waiting for a move, saturates instead of wrapping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         contagem <= '0;
      end else if (state != ESPERA_JOGADA) begin
         contagem <= '0;
      end else if (contagem != 16'hFFFF) begin
         contagem <= contagem + 16'd1;
      end
   end

   assign expirou_c = (contagem == ULTIMO);
   assign n_timeout = (next_state == FIM_TIMEOUT);

   always_ff @(posedge clock) begin
      if (!reset) begin
         timeout <= 1'b0;
      end else begin
         timeout <= n_timeout;
      end
   end
`else
   assign expirou_c = 1'b0;
   assign timeout   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= INICIAL;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a move always takes priority over the timeout.
   always_comb begin
      next_state = state;
      case (state)
         INICIAL:       if (iniciar) next_state = PREPARACAO;
         PREPARACAO:    next_state = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada) begin
               next_state = REGISTRA;
            end else if (expirou_c) begin
               next_state = FIM_TIMEOUT;
            end
         end
         REGISTRA:      next_state = COMPARACAO;
         COMPARACAO: begin
            if (!igual) begin
               next_state = FIM_ERROU;
            end else if (fimC) begin
               next_state = FIM_ACERTOU;
            end else begin
               next_state = PROXIMO;
            end
         end
         PROXIMO:       next_state = ESPERA_JOGADA;
         FIM_ACERTOU,
         FIM_ERROU,
         FIM_TIMEOUT:   if (iniciar) next_state = PREPARACAO;
         default:       next_state = INICIAL;
      endcase
   end

   // Moore outputs decoded from the next state so they are registered yet aligned with state.
   always_comb begin
      n_zera     = 1'b0;
      n_conta    = 1'b0;
      n_registra = 1'b0;
      n_pronto   = 1'b0;
      n_acertou  = 1'b0;
      n_errou    = 1'b0;
      case (next_state)
         PREPARACAO:  n_zera     = 1'b1;
         REGISTRA:    n_registra = 1'b1;
         PROXIMO:     n_conta    = 1'b1;
         FIM_ACERTOU: begin
            n_pronto  = 1'b1;
            n_acertou = 1'b1;
         end
         FIM_ERROU: begin
            n_pronto = 1'b1;
            n_errou  = 1'b1;
         end
         FIM_TIMEOUT: n_pronto   = 1'b1;
         default:     n_pronto   = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         zeraC     <= 1'b0;
         zeraR     <= 1'b0;
         contaC    <= 1'b0;
         registraR <= 1'b0;
         pronto    <= 1'b0;
         acertou   <= 1'b0;
         errou     <= 1'b0;
      end else begin
         zeraC     <= n_zera;
         zeraR     <= n_zera;
         contaC    <= n_conta;
         registraR <= n_registra;
         pronto    <= n_pronto;
         acertou   <= n_acertou;
         errou     <= n_errou;
      end
   end

   assign db_estado = state;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for exp4_unidade_controle: directed rounds then random traffic, checked every cycle
// against a behavioural model of the game rules. Build with or without TIMEOUT_EN.
module tb_exp4_unidade_controle;

   localparam int unsigned T = 8;

   logic       clock = 1'b0;
   logic       reset, iniciar, jogada, igual, fimC;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int vectors     = 0;
   int miscompares = 0;
   bit ten         = 1'b0;
   int m_st        = 0;  // expected db_estado code
   int m_wait      = 0;  // consecutive cycles already spent waiting for a move
   int n_reg, n_conta, n_zera;

   exp4_unidade_controle #(.TIMEOUT_CYCLES(T)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
      .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
      .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // Game rules: where the controller goes from code st given the sampled inputs.
   function automatic int rule_next(int st, int waited, logic ini, logic jog, logic ig, logic fc);
      case (st)
         0:          return ini ? 1 : 0;
         1:          return 2;
         2: begin
            if (jog) return 4;
            if (ten && waited + 1 >= int'(T)) return 13;
            return 2;
         end
         4:          return 5;
         5:          return !ig ? 14 : (fc ? 10 : 6);
         6:          return 2;
         10, 13, 14: return ini ? 1 : st;
         default:    return 0;
      endcase
   endfunction

   task automatic cycle(input logic r, input logic ini, input logic jog,
                        input logic ig, input logic fc, input string tag);
      logic [7:0] got, exp;
      int nst;
      reset = r; iniciar = ini; jogada = jog; igual = ig; fimC = fc;
      @(posedge clock);
      if (!r) begin
         m_st = 0; m_wait = 0;
      end else begin
         nst    = rule_next(m_st, m_wait, ini, jog, ig, fc);
         m_wait = (m_st == 2 && nst == 2) ? m_wait + 1 : 0;
         m_st   = nst;
      end
      #1;
      exp = {m_st == 1, m_st == 6, m_st == 1, m_st == 4,
             m_st == 10 || m_st == 13 || m_st == 14, m_st == 10, m_st == 14, m_st == 13};
      got = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
      n_reg   += int'(registraR);
      n_conta += int'(contaC);
      n_zera  += int'(zeraC);
      vectors++;
      assert (db_estado === 4'(m_st)) else begin
         miscompares++;
         $error("FAIL %s db_estado got %h expected %h", tag, db_estado, 4'(m_st));
      end
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s outputs{zC,cC,zR,rR,pr,ac,er,to} got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_count(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s count got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
   endtask

   task automatic clear_counts();
      n_reg = 0; n_conta = 0; n_zera = 0;
   endtask

   initial begin
`ifdef TIMEOUT_EN
      ten = 1'b1;
`endif
      clear_counts();
      reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;

      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset1");
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reset2");
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "jogada_in_inicial");

      // Full-match round of four moves.
      clear_counts();
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "start");
      idle(1, "prep");
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "move");
         idle(1, "registra");
         cycle(1'b1, 1'b0, 1'b0, 1'b1, (i == 3), "compara");
         if (i < 3) idle(1, "proximo");
      end
      check_count("registraR_pulses", n_reg, 4);
      check_count("contaC_pulses", n_conta, 3);
      check_count("zeraC_pulses", n_zera, 1);
      idle(2, "hold_acertou");

      // Mismatch on the second move, then restart from FIM_ERROU.
      clear_counts();
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "start2");
      idle(1, "prep2");
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "move1");
      idle(1, "reg1");
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "cmp1");
      idle(1, "prox1");
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "move2");
      idle(1, "reg2");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "cmp2_wrong");
      check_count("contaC_mismatch", n_conta, 1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "hold_errou");
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "restart_from_errou");
      idle(1, "prep3");

`ifdef TIMEOUT_EN
      // Eight idle cycles in ESPERA_JOGADA expire; a move on the eighth wins instead.
      idle(T, "timeout_expiry");
      idle(1, "hold_timeout");
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "restart_from_timeout");
      idle(1, "prep4");
      idle(T - 1, "wait_to_boundary");
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "jogada_at_boundary");
`else
      idle(200, "no_timeout_wait");
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "late_move");
`endif
      idle(1, "to_comparacao");
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "reset_mid_round");
      idle(1, "after_reset");
      clear_counts();
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "restart_after_reset");
      check_count("zeraC_after_restart", n_zera, 1);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 39) != 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0),
               "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/exp4_unidade_controle.md
EXP4_UNIDADE_CONTROLE -- requirements
Module: exp4_unidade_controle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000: idle cycles allowed in ESPERA_JOGADA before timeout; legal range 2..65535.
REQ-002 clock  input  1  system clock; all state changes occur on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled only on the rising edge of clock.
REQ-004 iniciar  input  1  start request, level-sampled.
REQ-005 jogada  input  1  one-cycle pulse from the datapath edge detector; a player move is present.
REQ-006 igual  input  1  chavesIgualMemoria from the datapath.
REQ-007 fimC  input  1  address counter is at its last position.
REQ-008 zeraC, contaC, zeraR, registraR  output  1 each  datapath controls.
REQ-009 pronto, acertou, errou, timeout  output  1 each  status outputs.
REQ-010 db_estado  output  4  state code, intended for hexa7seg.

Function
REQ-011 The block SHALL be a Moore FSM with state codes INICIAL=0, PREPARACAO=1, ESPERA_JOGADA=2, REGISTRA=4, COMPARACAO=5, PROXIMO=6, FIM_ACERTOU=A, FIM_ERROU=E, FIM_TIMEOUT=D. db_estado SHALL equal the current state code.
REQ-012 INICIAL: if iniciar=1, go to PREPARACAO. Otherwise, stay in INICIAL.
REQ-013 PREPARACAO: assert zeraC=1 and zeraR=1 for exactly one cycle, then go unconditionally to ESPERA_JOGADA.
REQ-014 ESPERA_JOGADA: if jogada=1, go to REGISTRA. Otherwise, if the timeout counter equals TIMEOUT_CYCLES-1, go to FIM_TIMEOUT. Otherwise, stay.
REQ-015 REGISTRA: assert registraR=1 for exactly one cycle, then go to COMPARACAO.
REQ-016 COMPARACAO: if igual=0, go to FIM_ERROU. If igual=1 and fimC=1, go to FIM_ACERTOU. If igual=1 and fimC=0, go to PROXIMO.
REQ-017 PROXIMO: assert contaC=1 for exactly one cycle, then go to ESPERA_JOGADA.
REQ-018 Terminal states:
  - FIM_* states SHALL assert pronto=1.
  - FIM_ACERTOU SHALL assert acertou=1; FIM_ERROU SHALL assert errou=1; FIM_TIMEOUT SHALL assert timeout=1.
  - These outputs SHALL hold while the FSM remains in the state.
  - iniciar=1 SHALL go to PREPARACAO. Otherwise, stay.
REQ-019 In any state, every output not listed for that state SHALL be 0. At most one of acertou, errou and timeout SHALL be 1 at any time.
REQ-020 Timeout counter:
  - 16 bits wide.
  - Cleared to 0 in every cycle the FSM is not in ESPERA_JOGADA.
  - Increments by 1 each cycle in ESPERA_JOGADA.
  - Never wraps.
REQ-021 Timeout boundary: the timeout transition SHALL occur after exactly TIMEOUT_CYCLES consecutive cycles in ESPERA_JOGADA without jogada.
REQ-022 If jogada=1 in the same cycle the counter reaches TIMEOUT_CYCLES-1, jogada SHALL win and the FSM SHALL go to REGISTRA.
REQ-023 jogada SHALL be ignored in every state except ESPERA_JOGADA.
REQ-024 Latency:
  - From a jogada in ESPERA_JOGADA to the verdict state: 3 edges (REGISTRA, COMPARACAO, verdict).
  - For a non-final correct move, the FSM SHALL return to ESPERA_JOGADA 3 edges after the jogada edge.

Reset
REQ-025 With reset=0 at a rising edge, the FSM SHALL enter INICIAL and clear the timeout counter. This SHALL override every other input and apply in any state, including mid-round.
REQ-026 After reset, all outputs SHALL be 0 and db_estado SHALL be 0 until iniciar is sampled high.

Configuration
REQ-027 Macro TIMEOUT_EN defined: the timeout counter, FIM_TIMEOUT and the timeout output SHALL be implemented as specified above.
REQ-028 Macro TIMEOUT_EN undefined:
  - No counter SHALL be synthesized and TIMEOUT_CYCLES SHALL be unused.
  - timeout SHALL be tied to 0 and FIM_TIMEOUT SHALL be unreachable.
  - ESPERA_JOGADA SHALL wait indefinitely for jogada.

Verification (TIMEOUT_CYCLES=8, TIMEOUT_EN defined unless noted)
REQ-029 Full-match round:
  - Stimulus: reset low for 2 cycles, then iniciar pulse, then 4 jogada pulses with igual=1 and fimC=1 on the 4th.
  - Response: zeraC and zeraR each high for 1 cycle, then registraR 4 times, contaC 3 times; FSM ends in FIM_ACERTOU with pronto=1, acertou=1, db_estado=A.
REQ-030 Mismatch:
  - Stimulus: second jogada with igual=0.
  - Response: FIM_ERROU, errou=1, pronto=1, db_estado=E, contaC pulsed exactly once.
REQ-031 Timeout:
  - Stimulus: no jogada for 8 cycles after entering ESPERA_JOGADA.
  - Response: 9th state is FIM_TIMEOUT, timeout=1, db_estado=D. A jogada on the 8th cycle instead yields REGISTRA.
REQ-032 Reset mid-round:
  - Stimulus: reset=0 while in COMPARACAO.
  - Response: next state is INICIAL, all outputs 0, db_estado=0. A later iniciar restarts with a PREPARACAO pulse.
REQ-033 Restart from terminal state:
  - Stimulus: iniciar=1 in FIM_ERROU.
  - Response: PREPARACAO next cycle, errou and pronto drop to 0.
REQ-034 TIMEOUT_EN undefined:
  - Stimulus: 200 idle cycles in ESPERA_JOGADA.
  - Response: FSM stays at db_estado=2 and timeout stays 0.
